audio_bypass_tester: RTL and testbench
======================================

Name: audio_bypass_tester

Overview:
- Parametrised, fully registered audio test block, inserted in place of the filter between the I2S receiver and the I2S transmitter.
- Detects L/R frame edges on l_r_clk and processes one sample per channel per frame.
- Four runtime-selectable modes verify wiring, arithmetic, per-channel memory and output gating: pass, attenuate, fixed N-sample delay, mute.
- Adds a sample_valid strobe so downstream logic and benches can align to processed samples.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- DELAY_DEPTH, 8, samples of delay per channel in DELAY mode; power of two, ≥2.
- SHIFT_W, 2, width of the attenuation shift control (max shift = 2^SHIFT_W−1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- l_r_clk  in  1  I2S word-select; 0 = left, 1 = right; asynchronous to clk.
- audio_in  in  DATA_W  signed sample from the receiver; stable for ≥4 clk after each l_r_clk edge.
- mode  in  2  00 PASS, 01 ATTEN, 10 DELAY, 11 MUTE.
- shift  in  SHIFT_W  attenuation amount for ATTEN.
- audio_out  out  DATA_W  signed processed sample, registered.
- sample_valid  out  1  one-clk pulse when audio_out updates.
- chan_out  out  1  channel of the current audio_out (0 L, 1 R).

Behaviour:
- Reset (async assert, sync release): audio_out=0, sample_valid=0, chan_out=0, synchroniser flops=0, delay memory all 0, write pointer=0.
- l_r_clk path:
  - 2-flop synchroniser (s1, s2) plus history flop s3.
  - strobe = s2 ^ s3; either edge counts.
  - channel = s2 at strobe.
- Cycle timing, with T = first clk edge that samples the new l_r_clk level into s1:
  - T+1: s2 updates.
  - T+2: strobe high; capture audio_in, mode, shift, channel into stage regs.
  - T+3: audio_out, chan_out and sample_valid register; sample_valid=1 for exactly that cycle.
  - Latency edge→output is fixed at 3 clk.
- Mode arithmetic on captured sample x:
  - PASS: out = x.
  - ATTEN: out = x >>> shift (arithmetic; −1>>>n = −1; shift 0 = x).
  - DELAY: out = sample of the same channel captured DELAY_DEPTH frames earlier; 0 until that many frames have elapsed since reset.
  - MUTE: out = 0.
- Delay memory:
  - 2×DELAY_DEPTH words, one bank per channel.
  - Written with x on every strobe in every mode, so history is valid when DELAY is entered.
  - Read-before-write at the shared write pointer: the read returns the old word, then x overwrites it.
  - Pointer advances, modulo DELAY_DEPTH, only after a right-channel write.
  - A left-only edge without a following right edge leaves the pointer unchanged.
- mode and shift are sampled only at strobe. A change mid-frame takes effect on the next strobe, with no glitch and no flush.
- Back-to-back edges closer than 4 clk are unsupported; behaviour is undefined and is not tested.
- Reset mid-frame: everything clears immediately. The first strobe after release sees s3=0, so an l_r_clk held high produces one strobe (chan R) after release, which is acceptable.
- audio_out holds its value between strobes; sample_valid=0 otherwise.

Decomposition:
- Package audio_test_pkg:
  - mode_t enum {MODE_PASS=2'b00, MODE_ATTEN=2'b01, MODE_DELAY=2'b10, MODE_MUTE=2'b11}.
  - AUDIO_W=16.
  - CH_LEFT=0, CH_RIGHT=1.
- Sub-module lr_edge_sync:
  - Ports: clk, reset, l_r_clk → strobe, chan.
  - 3 flops; reused later by the filter pipeline.
- Delay memory stays inline as a register array; at default depth it is too small to justify a RAM macro.

Test Plan:
- Reset then PASS: drive L=16'sh1234, R=−16'sh0100 on successive l_r_clk edges → audio_out=16'sh1234 (chan 0), then 16'shFF00 (chan 1), each with sample_valid exactly 3 clk after the edge. Assert reset mid-stream → audio_out=0 immediately.
- ATTEN sweep: x=−16'sh4000, shift=0..3 → −16'sh4000, −16'sh2000, −16'sh1000, −16'sh0800. x=−1, shift=3 → −1.
- DELAY from reset, DELAY_DEPTH=8: feed L=k, R=100+k for frames k=1..12 → frames 1–8 output 0; frame 9 outputs L=1, R=101; frame 12 outputs L=4, R=104.
- Mode history: run PASS for 10 frames (L=k), switch to DELAY at frame 11 → output L=3, i.e. history was written while in PASS.
- MUTE and mid-frame switch: change mode from PASS to MUTE one cycle after a strobe → that sample is PASS and the next strobe outputs 0. sample_valid still pulses in MUTE.
- Pulse count: hold l_r_clk constant for 200 clk → no sample_valid. Then toggle 10 times → exactly 10 pulses, alternating chan_out.

Source files
------------

// File: rtl/audio_test_pkg.sv
// Shared types and constants for the audio bypass/test datapath.
package audio_test_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_ATTEN = 2'b01,
        MODE_DELAY = 2'b10,
        MODE_MUTE  = 2'b11
    } mode_t;

    localparam int AUDIO_W = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/lr_edge_sync.sv
// Synchronises the I2S word-select into clk and flags either edge as a one-cycle strobe.
module lr_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic l_r_clk,
    output logic strobe,
    output logic chan
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = l_r_clk;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign strobe = s2_q ^ s3_q;
    assign chan   = s2_q;

endmodule

// File: rtl/audio_bypass_tester.sv
// Test stand-in for the audio filter: pass, attenuate, per-channel delay or mute,
// one sample per l_r_clk edge with a fixed 3-clk edge-to-output latency.
module audio_bypass_tester
    import audio_test_pkg::*;
#(
    parameter int DATA_W      = AUDIO_W,
    parameter int DELAY_DEPTH = 8,
    parameter int SHIFT_W     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     l_r_clk,
    input  logic signed [DATA_W-1:0] audio_in,
    input  logic [1:0]               mode,
    input  logic [SHIFT_W-1:0]       shift,
    output logic signed [DATA_W-1:0] audio_out,
    output logic                     sample_valid,
    output logic                     chan_out
);

    localparam int PTR_W = $clog2(DELAY_DEPTH);

    logic strobe;
    logic chan;

    lr_edge_sync u_lr_edge_sync (
        .clk     (clk),
        .reset   (reset),
        .l_r_clk (l_r_clk),
        .strobe  (strobe),
        .chan    (chan)
    );

    logic signed [DATA_W-1:0] x_q, x_d;
    mode_t                    mode_q, mode_d;
    logic [SHIFT_W-1:0]       shift_q, shift_d;
    logic                     chan_q, chan_d;
    logic                     stage_vld_q, stage_vld_d;

    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     vld_q, vld_d;
    logic                     chan_out_q, chan_out_d;

    logic signed [DATA_W-1:0] mem_q [2][DELAY_DEPTH];
    logic signed [DATA_W-1:0] mem_d [2][DELAY_DEPTH];
    logic [PTR_W-1:0]         wptr_q, wptr_d;
    logic signed [DATA_W-1:0] rd_word;

    always_comb begin
        x_d         = x_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        chan_d      = chan_q;
        stage_vld_d = strobe;
        out_d       = out_q;
        vld_d       = 1'b0;
        chan_out_d  = chan_out_q;
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rd_word     = mem_q[chan_q][wptr_q];

        if (strobe) begin
            x_d     = audio_in;
            mode_d  = mode_t'(mode);
            shift_d = shift;
            chan_d  = chan;
        end

        // History is written in every mode so DELAY has valid data the moment it is selected.
        if (stage_vld_q) begin
            case (mode_q)
                MODE_PASS:  out_d = x_q;
                MODE_ATTEN: out_d = x_q >>> shift_q;
                MODE_DELAY: out_d = rd_word;
                default:    out_d = '0;
            endcase
            vld_d                 = 1'b1;
            chan_out_d            = chan_q;
            mem_d[chan_q][wptr_q] = x_q;
            if (chan_q == CH_RIGHT) begin
                wptr_d = wptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q         <= '0;
            mode_q      <= MODE_PASS;
            shift_q     <= '0;
            chan_q      <= CH_LEFT;
            stage_vld_q <= 1'b0;
            out_q       <= '0;
            vld_q       <= 1'b0;
            chan_out_q  <= CH_LEFT;
            wptr_q      <= '0;
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < DELAY_DEPTH; i++) begin
                    mem_q[c][i] <= '0;
                end
            end
        end else begin
            x_q         <= x_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            chan_q      <= chan_d;
            stage_vld_q <= stage_vld_d;
            out_q       <= out_d;
            vld_q       <= vld_d;
            chan_out_q  <= chan_out_d;
            wptr_q      <= wptr_d;
            mem_q       <= mem_d;
        end
    end

    assign audio_out    = out_q;
    assign sample_valid = vld_q;
    assign chan_out     = chan_out_q;

endmodule

// File: tb/tb_audio_bypass_tester.sv
// Randomised and directed bench for audio_bypass_tester against a per-channel history model.
module tb_audio_bypass_tester;

    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               l_r_clk = 1'b0;
    logic signed [15:0] audio_in = '0;
    logic [1:0]         mode = 2'b00;
    logic [1:0]         shift = 2'b00;
    logic signed [15:0] audio_out;
    logic               sample_valid;
    logic               chan_out;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    longint last_out = 0;

    int hq_l[$];
    int hq_r[$];

    audio_bypass_tester #(.DATA_W(16), .DELAY_DEPTH(DEPTH), .SHIFT_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .l_r_clk      (l_r_clk),
        .audio_in     (audio_in),
        .mode         (mode),
        .shift        (shift),
        .audio_out    (audio_out),
        .sample_valid (sample_valid),
        .chan_out     (chan_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && sample_valid) pulse_cnt++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected output for a sample captured on channel ch; records x as that channel's history.
    function automatic int model(input int ch, input int m, input int s, input int x);
        int size, r, div;
        size = (ch == 0) ? hq_l.size() : hq_r.size();
        div  = 1 << s;
        case (m)
            0: r = x;
            1: r = (x >= 0) ? x / div : -((-x + div - 1) / div);
            2: r = (size >= DEPTH) ? ((ch == 0) ? hq_l[size-DEPTH] : hq_r[size-DEPTH]) : 0;
            default: r = 0;
        endcase
        if (ch == 0) hq_l.push_back(x); else hq_r.push_back(x);
        return r;
    endfunction

    task automatic do_edge(input int d, input int sw_mode);
        int     e, n;
        longint got, gch;
        logic   after;
        @(negedge clk);
        audio_in = 16'(d);
        l_r_clk  = ~l_r_clk;
        e = model(int'(l_r_clk), int'(mode), int'(shift), d);
        n = 0; got = 0; gch = 0; after = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 3 && sw_mode >= 0) mode = 2'(sw_mode);
            if (n != 0 && i == n + 1) after = sample_valid;
            if (sample_valid && n == 0) begin
                n   = i;
                got = audio_out;
                gch = chan_out;
            end
        end
        check("latency", n, 4);
        check("data", got, e);
        check("chan", gch, l_r_clk);
        check("pulse_width", after, 0);
        last_out = got;
    endtask

    // Reset, then one priming edge so later frames start on the left channel.
    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        l_r_clk = 1'b0;
        hq_l.delete();
        hq_r.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        do_edge(0, -1);
    endtask

    initial begin
        int p0;
        int att_exp[4];
        att_exp = '{-'h4000, -'h2000, -'h1000, -'h0800};

        repeat (3) @(negedge clk);
        check("rst_audio_out", audio_out, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_chan", chan_out, 0);
        reset = 1'b0;
        do_edge(0, -1);

        // PASS
        mode = 2'b00;
        do_edge('h1234, -1);
        check("pass_left", last_out, 'h1234);
        do_edge(-256, -1);
        check("pass_right", last_out, -256);
        do_edge('h1234, -1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("midreset_out", audio_out, 0);
        check("midreset_valid", sample_valid, 0);
        l_r_clk = 1'b0;
        hq_l.delete();
        hq_r.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        do_edge(0, -1);

        // ATTEN sweep
        mode = 2'b01;
        for (int s = 0; s < 4; s++) begin
            shift = 2'(s);
            do_edge(-'h4000, -1);
            check("atten_sweep", last_out, att_exp[s]);
            do_edge(-'h4000, -1);
        end
        shift = 2'd3;
        do_edge(-1, -1);
        check("atten_minus1", last_out, -1);
        do_edge(-1, -1);

        // DELAY from reset
        mode = 2'b10;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            do_edge(k, -1);
            if (k == 9)  check("delay_f9_l", last_out, 1);
            if (k == 12) check("delay_f12_l", last_out, 4);
            do_edge(100 + k, -1);
            if (k == 9)  check("delay_f9_r", last_out, 101);
            if (k == 12) check("delay_f12_r", last_out, 104);
        end

        // History written while in PASS
        mode = 2'b00;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            do_edge(k, -1);
            do_edge(100 + k, -1);
        end
        mode = 2'b10;
        do_edge(11, -1);
        check("history_l", last_out, 3);
        do_edge(111, -1);

        // Mid-frame switch to MUTE
        mode = 2'b00;
        do_edge('h0777, 3);
        check("switch_pass", last_out, 'h0777);
        do_edge('h0555, -1);
        check("switch_mute", last_out, 0);

        // Random modes, shifts and samples
        for (int j = 0; j < 60; j++) begin
            mode  = 2'($urandom_range(0, 3));
            shift = 2'($urandom_range(0, 3));
            do_edge(int'($signed(16'($urandom))), -1);
        end

        // Pulse count
        p0 = pulse_cnt;
        repeat (200) @(posedge clk);
        check("idle_pulses", pulse_cnt - p0, 0);
        mode = 2'b00;
        p0 = pulse_cnt;
        for (int j = 0; j < 10; j++) do_edge(j + 1, -1);
        check("toggle_pulses", pulse_cnt - p0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
